cdb_arbiter: RTL and testbench

Collects completed results from the execution units (ALU pipes, multiplier, load unit) and broadcasts up to CDB_W of them per cycle on the common data bus. The bus wakes up operands in reservation_station and marks ROB entries complete. Each source gets a small FIFO, and a round-robin arbiter packs granted results onto CDB lanes. CDB outputs come straight from flops, so the station's combinational wakeup never sees a long path.

---
 rtl/core_pkg.sv | 15 +
 rtl/cdb_src_fifo.sv | 54 +++++
 rtl/cdb_arbiter.sv | 114 +++++++++++
 tb/tb_cdb_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: CDB geometry defaults and the result packet carried
// from execution units through the CDB arbiter to stations and the ROB.
package core_pkg;

    localparam int DEF_CDB_W  = 2;
    localparam int DEF_PHYS_W = 6;
    localparam int DEF_ROB_W  = 6;

    typedef struct packed {
        logic [DEF_PHYS_W-1:0] tag;
        logic [63:0]           value;
        logic [DEF_ROB_W-1:0]  rob_tag;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Small per-source result FIFO feeding the CDB arbiter; exposes its registered
// occupancy and head entry so the arbiter can pick without extra latency.
module cdb_src_fifo
    import core_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  cdb_pkt_t         pkt_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output cdb_pkt_t         head_o
);

    cdb_pkt_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: payload storage is deliberately not reset; count_q alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= pkt_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source FIFOs, round-robin packing of up to CDB_W
// results per cycle onto lanes, and flop-driven CDB outputs.
module cdb_arbiter
    import core_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int CDB_W      = DEF_CDB_W,
    parameter int PHYS_W     = DEF_PHYS_W,
    parameter int ROB_W      = DEF_ROB_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           flush,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC-1:0][PHYS_W-1:0] src_tag,
    input  logic [NUM_SRC-1:0][63:0]       src_value,
    input  logic [NUM_SRC-1:0][ROB_W-1:0]  src_rob_tag,
    output logic [CDB_W-1:0]               cdb_valid,
    output logic [CDB_W-1:0][PHYS_W-1:0]   cdb_tag,
    output logic [CDB_W-1:0][63:0]         cdb_value,
    output logic [CDB_W-1:0][ROB_W-1:0]    cdb_rob_tag
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    cdb_pkt_t [NUM_SRC-1:0]            src_pkt;
    cdb_pkt_t [NUM_SRC-1:0]            head;
    logic     [NUM_SRC-1:0][CNT_W-1:0] count;
    logic     [NUM_SRC-1:0]            push;
    logic     [NUM_SRC-1:0]            nonempty;
    logic     [NUM_SRC-1:0]            grant;

    logic     [SRC_W-1:0]              rr_q, rr_d;
    logic     [CDB_W-1:0]              lane_vld;
    logic     [CDB_W-1:0][SRC_W-1:0]   lane_src;
    cdb_pkt_t [CDB_W-1:0]              lane_pkt;
    logic     [CDB_W-1:0]              cdb_valid_q;
    cdb_pkt_t [CDB_W-1:0]              cdb_pkt_q;

    // Ready comes only from the registered count, never from this cycle's pop.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign src_pkt[s]   = {src_tag[s], src_value[s], src_rob_tag[s]};
        assign src_ready[s] = count[s] < CNT_W'(FIFO_DEPTH);
        assign push[s]      = src_valid[s] & src_ready[s] & ~flush;
        assign nonempty[s]  = count[s] != '0;

        cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .flush_i (flush),
            .push_i  (push[s]),
            .pkt_i   (src_pkt[s]),
            .pop_i   (grant[s]),
            .count_o (count[s]),
            .head_o  (head[s])
        );
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        int n_granted;
        grant     = '0;
        lane_vld  = '0;
        lane_src  = '0;
        rr_d      = rr_q;
        n_granted = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (!flush && nonempty[s] && n_granted < CDB_W &&
                    s == (int'(rr_q) + k) % NUM_SRC) begin
                    grant[s] = 1'b1;
                    for (int l = 0; l < CDB_W; l++) begin
                        if (l == n_granted) begin
                            lane_vld[l] = 1'b1;
                            lane_src[l] = SRC_W'(s);
                        end
                    end
                    rr_d      = SRC_W'((s + 1) % NUM_SRC);
                    n_granted = n_granted + 1;
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < CDB_W; l++) lane_pkt[l] = head[lane_src[l]];
    end

    // Idle lanes keep stale payload; consumers qualify with cdb_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q        <= '0;
            cdb_valid_q <= '0;
            cdb_pkt_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            cdb_valid_q <= lane_vld;
            for (int l = 0; l < CDB_W; l++) begin
                if (lane_vld[l]) cdb_pkt_q[l] <= lane_pkt[l];
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    for (genvar l = 0; l < CDB_W; l++) begin : g_lane
        assign cdb_tag[l]     = cdb_pkt_q[l].tag;
        assign cdb_value[l]   = cdb_pkt_q[l].value;
        assign cdb_rob_tag[l] = cdb_pkt_q[l].rob_tag;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected lane outputs into a
// scoreboard queue, and a negedge monitor pops and compares them cycle by cycle.
module tb_cdb_arbiter;
    import core_pkg::*;

    logic            clk       = 1'b0;
    logic            reset_n   = 1'b0;
    logic            flush     = 1'b0;
    logic [3:0]      src_valid = '0;
    logic [3:0]      src_ready;
    logic [3:0][5:0] src_tag;
    logic [3:0][63:0] src_value;
    logic [3:0][5:0] src_rob_tag;
    logic [1:0]      cdb_valid;
    logic [1:0][5:0] cdb_tag;
    logic [1:0][63:0] cdb_value;
    logic [1:0][5:0] cdb_rob_tag;

    cdb_arbiter #(
        .NUM_SRC(4), .CDB_W(2), .PHYS_W(6), .ROB_W(6), .FIFO_DEPTH(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_tag     (src_tag),
        .src_value   (src_value),
        .src_rob_tag (src_rob_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .cdb_rob_tag (cdb_rob_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          lane;
        logic [5:0]  tag;
        logic [63:0] value;
        logic [5:0]  rob;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_here;
    logic mon_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   c, c0;
    int   n_push[4];
    logic [3:0] hs;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int at, input int lane, input logic [5:0] tag,
                            input logic [63:0] value, input logic [5:0] rob);
        exp_t e;
        e.cyc = at; e.lane = lane; e.tag = tag; e.value = value; e.rob = rob;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        src_valid = '0;
        flush     = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic set_src(input int s, input logic [5:0] tag, input logic [63:0] value,
                           input logic [5:0] rob);
        src_valid[s]   = 1'b1;
        src_tag[s]     = tag;
        src_value[s]   = value;
        src_rob_tag[s] = rob;
    endtask

    // Streaming payload for source s, item j.
    function automatic logic [5:0] ftag(input int s, input int j);
        return 6'(s * 8 + j);
    endfunction
    function automatic logic [63:0] fval(input int s, input int j);
        return 64'hF00D_0000_0000_0000 + 64'(s * 256 + j);
    endfunction
    function automatic logic [5:0] frob(input int s, input int j);
        return 6'(63 - s * 8 - j);
    endfunction

    // Hand-derived ready pattern with all four sources streaming from empty:
    // sources 0/1 and 2/3 fill on alternate cycles once the {0,1},{2,3} grant rhythm starts.
    function automatic logic [3:0] exp_ready(input int t);
        if (t < 2)       return 4'b1111;
        else if (t % 2 == 0) return 4'b0011;
        else             return 4'b1100;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("exp_overdue_cycle", 128'(exp_q[0].cyc), 128'(cyc));
                void'(exp_q.pop_front());
            end
            for (int l = 0; l < 2; l++) begin
                mon_here = exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].lane == l;
                if (cdb_valid[l] || mon_here)
                    check($sformatf("cdb_valid[%0d]@%0d", l, cyc), 128'(cdb_valid[l]), 128'(mon_here));
                if (mon_here) begin
                    mon_e = exp_q.pop_front();
                    if (cdb_valid[l])
                        check($sformatf("cdb_pkt[%0d]@%0d", l, cyc),
                              128'({cdb_tag[l], cdb_value[l], cdb_rob_tag[l]}),
                              128'({mon_e.tag, mon_e.value, mon_e.rob}));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        src_tag = '0; src_value = '0; src_rob_tag = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_cdb_valid", 128'(cdb_valid), 128'(2'b00));
        check("rst_cdb_tag", 128'(cdb_tag), 128'(0));
        check("rst_cdb_value", 128'(cdb_value), 128'(0));
        check("rst_cdb_rob_tag", 128'(cdb_rob_tag), 128'(0));
        check("rst_src_ready", 128'(src_ready), 128'(4'hF));
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        idle(2);

        // Single result from src1: lane 0 two cycles later, lane 1 idle
        next_cycle();
        c = cyc;
        set_src(1, 6'd5, 64'hDEAD_BEEF, 6'd3);
        push_exp(c + 2, 0, 6'd5, 64'hDEAD_BEEF, 6'd3);
        next_cycle();
        idle(4);

        // Reset asserted mid-cycle while lanes are busy
        mon_en = 1'b0;
        next_cycle();
        for (int s = 0; s < 4; s++) set_src(s, 6'h3F, 64'hBAD0 + 64'(s), 6'h3F);
        next_cycle();
        next_cycle();
        #2;
        reset_n   = 1'b0;
        src_valid = '0;
        #1;
        check("rst_async_cdb_valid", 128'(cdb_valid), 128'(2'b00));
        check("rst_async_src_ready", 128'(src_ready), 128'(4'hF));
        check("rst_async_cdb_pkt", 128'({cdb_tag, cdb_rob_tag}), 128'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        idle(5);

        // Contention with rr_ptr = 0: src0/src1 first, src2 one cycle later
        next_cycle();
        c = cyc;
        set_src(0, 6'h0A, 64'h1111, 6'h10);
        set_src(1, 6'h0B, 64'h2222, 6'h11);
        set_src(2, 6'h0C, 64'h3333, 6'h12);
        push_exp(c + 2, 0, 6'h0A, 64'h1111, 6'h10);
        push_exp(c + 2, 1, 6'h0B, 64'h2222, 6'h11);
        push_exp(c + 3, 0, 6'h0C, 64'h3333, 6'h12);
        next_cycle();
        idle(4);

        // rr_ptr now 3: lone src3 result, pointer wraps back to 0
        next_cycle();
        c = cyc;
        set_src(3, 6'h21, 64'h0123_4567_89AB_CDEF, 6'h2A);
        push_exp(c + 2, 0, 6'h21, 64'h0123_4567_89AB_CDEF, 6'h2A);
        next_cycle();
        idle(4);

        // Fairness and backpressure: all sources stream 6 results each
        hs = '0;
        for (int s = 0; s < 4; s++) n_push[s] = 0;
        for (int t = 0; t < 16; t++) begin
            next_cycle();
            if (t == 0) begin
                c0 = cyc;
                for (int j = 0; j < 6; j++)
                    for (int p = 0; p < 2; p++)
                        for (int l = 0; l < 2; l++)
                            push_exp(c0 + 2 + 2 * j + p, l, ftag(2 * p + l, j),
                                     fval(2 * p + l, j), frob(2 * p + l, j));
            end
            for (int s = 0; s < 4; s++) begin
                if (hs[s]) n_push[s]++;
                src_valid[s]   = n_push[s] < 6;
                src_tag[s]     = ftag(s, n_push[s]);
                src_value[s]   = fval(s, n_push[s]);
                src_rob_tag[s] = frob(s, n_push[s]);
            end
            @(negedge clk);
            if (t <= 8) check($sformatf("src_ready_stream_t%0d", t), 128'(src_ready), 128'(exp_ready(t)));
            hs = src_valid & src_ready;
        end
        idle(4);

        // Flush: fill, flush one cycle with handshakes pending, nothing survives
        next_cycle();
        c = cyc;
        for (int s = 0; s < 4; s++) set_src(s, 6'(16 + s * 4), 64'hC0DE_0000 + 64'(s * 16), 6'(s));
        next_cycle();
        for (int s = 0; s < 4; s++) set_src(s, 6'(17 + s * 4), 64'hC0DE_0001 + 64'(s * 16), 6'(8 + s));
        push_exp(c + 2, 0, 6'd16, 64'hC0DE_0000, 6'd0);
        push_exp(c + 2, 1, 6'd20, 64'hC0DE_0010, 6'd1);
        next_cycle();
        flush = 1'b1;
        for (int s = 0; s < 4; s++) set_src(s, 6'(18 + s * 4), 64'hC0DE_0002 + 64'(s * 16), 6'(16 + s));
        next_cycle();
        flush     = 1'b0;
        src_valid = '0;
        @(negedge clk);
        check("flush_next_cdb_valid", 128'(cdb_valid), 128'(2'b00));
        check("flush_next_src_ready", 128'(src_ready), 128'(4'hF));
        idle(5);

        // rr_ptr survived the flush at 2: src2 takes lane 0 ahead of src0
        next_cycle();
        c = cyc;
        set_src(0, 6'h31, 64'hAAAA_0000, 6'h01);
        set_src(2, 6'h32, 64'hBBBB_0000, 6'h02);
        push_exp(c + 2, 0, 6'h32, 64'hBBBB_0000, 6'h02);
        push_exp(c + 2, 1, 6'h31, 64'hAAAA_0000, 6'h01);
        next_cycle();
        idle(4);

        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
